mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only when not busy.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Read_Data_1  input  32  rs operand (multiplicand or dividend).
REQ-007 Read_Data_2  input  32  rt operand (multiplier or divisor).
REQ-008 hi_we, lo_we  input  1 each  MTHI/MTLO write strobes.
REQ-009 Write_Data  input  32  data for MTHI/MTLO.
REQ-010 busy  output  1  operation in progress.
REQ-011 done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-012 Hi, Lo  output  32 each  architectural HI/LO registers, read by MFHI/MFLO.
REQ-013 div_zero  output  1  last DIV/DIVU had a zero divisor; cleared by the next accepted start.

Function
REQ-014 FSM states: IDLE, RUN, FIX, DONE.
REQ-015 IDLE/DONE with start=1: latch operands, latch op and take operand magnitudes for MULT/DIV; iteration count := 0; go to RUN; busy=1 from the next cycle.
REQ-016 RUN: one shift-add (mult) or restoring-subtract (div) step per cycle, 32 cycles; after step 32, go to FIX.
REQ-017 FIX: sign-correct the result and write HI/LO on the exit edge; go to DONE.
REQ-018 DONE: done=1, busy=0 for exactly one cycle; then IDLE unless start=1.
REQ-019 Latency: a start sampled at edge E0 gives done=1 and valid HI/LO after edge E33.
REQ-020 MULT/MULTU: {Hi,Lo} is the 64-bit signed/unsigned product.
REQ-021 DIV/DIVU: Lo = quotient truncated toward zero; Hi = remainder with the sign of the dividend.
REQ-022 Divide by zero: Lo=32'hFFFFFFFF, Hi=dividend, div_zero=1; latency unchanged.
REQ-023 DIV 32'h80000000 / 32'hFFFFFFFF: Lo=32'h80000000, Hi=0, div_zero=0.
REQ-024 start while busy: ignored; the operation in flight is undisturbed.
REQ-025 hi_we/lo_we while busy: ignored.
REQ-026 hi_we/lo_we in IDLE/DONE: load the register on that edge.
REQ-027 start together with hi_we/lo_we in IDLE/DONE: start wins; the write is dropped.
REQ-028 Hi/Lo change only at the FIX exit edge, on accepted writes, or on reset.

Reset
REQ-029 Asynchronous reset drives: state=IDLE, Hi=0, Lo=0, busy=0, done=0, div_zero=0.
REQ-030 Reset during RUN/FIX aborts the operation; no partial result reaches Hi/Lo.
REQ-031 The first start is accepted at the first rising edge after reset deasserts.

Configuration
REQ-032 Macro MDU_FAST_MUL_EN defined: MULT/MULTU use a single-cycle combinational multiplier; a start at E0 gives done after E1 with Hi/Lo valid.
REQ-033 With MDU_FAST_MUL_EN defined, DIV/DIVU are unchanged at 33-cycle latency.
REQ-034 MDU_FAST_MUL_EN undefined: all ops are iterative per REQ-016..019.

Structure
REQ-035 Package mdu_pkg holds: op encodings, FSM state enum, and the constant MDU_ITER=32.
REQ-036 Sub-module mdu_div_core holds the restoring-divide step datapath (remainder/quotient registers); the top holds FSM, sign handling and HI/LO.

Verification
REQ-037 MULT 32'hFFFFFFFE x 32'h00000003 -> after 33 cycles Hi=32'hFFFFFFFF, Lo=32'hFFFFFFFA, done pulse 1 cycle.
REQ-038 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> Hi=32'hFFFFFFFE, Lo=32'h00000001.
REQ-039 DIV -7 / 2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF; DIVU 100/0 -> Lo=32'hFFFFFFFF, Hi=100, div_zero=1.
REQ-040 Second start and lo_we pulsed at cycle 10 of a DIV -> both ignored; result matches the first operands.
REQ-041 Reset asserted at cycle 20 of a MULT -> Hi=Lo=0, busy=0 immediately; a new MULT 6x7 then yields Lo=42.
REQ-042 With MDU_FAST_MUL_EN: MULT 6x7 -> done one cycle after start, Lo=42, Hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// controller states, the iteration count and small op-decoding helpers.
package mdu_pkg;

    localparam int MDU_ITER  = 32;
    localparam int MDU_CNT_W = $clog2(MDU_ITER) + 1;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider datapath: one quotient bit per step on unsigned
// magnitudes. Sign correction and divide-by-zero handling live in the top.
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;

    // Trial subtraction: shift the next dividend bit into the partial
    // remainder and test it against the divisor. When it fits, the true
    // difference is below the divisor, so the low WIDTH bits are exact.
    always_comb begin
        shifted = {rem_reg, quo_reg[WIDTH-1]};
        fits    = (shifted >= {1'b0, dsr_reg});
        diff    = shifted[WIDTH-1:0] - dsr_reg;
    end

    // Load operands on an accepted start, then retire one quotient bit per step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_reg <= '0;
            quo_reg <= '0;
            dsr_reg <= '0;
        end else if (load) begin
            rem_reg <= '0;
            quo_reg <= dividend;
            dsr_reg <= divisor;
        end else if (step) begin
            if (fits) begin
                rem_reg <= diff;
                quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
            end else begin
                rem_reg <= shifted[WIDTH-1:0];
                quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit. Iterative 32-step shift-add
// multiply and restoring divide, then a sign-fix cycle that writes HI/LO.
// Optional macro MDU_FAST_MUL_EN: MULT/MULTU use a single-cycle
// combinational multiplier and skip the iterative phase.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] Read_Data_1,
    input  logic [WIDTH-1:0] Read_Data_2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] Write_Data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             div_zero
);

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    mdu_state_e           state_reg, state_next;
    logic [MDU_CNT_W-1:0] iter_reg;
    mdu_op_e              op_reg;
    logic                 neg_a_reg, neg_b_reg;
    logic [WIDTH-1:0]     dividend_reg;
    logic                 zero_div_reg;
    logic [WIDTH-1:0]     hi_reg, lo_reg;
    logic                 div_zero_reg;
    logic [WIDTH-1:0]     mcand_reg, prod_lo_reg;

    mdu_op_e              op_in;
    logic                 signed_in;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 idle_like, accept, last_iter;
    logic [2*WIDTH-1:0]   mag_prod, signed_prod;
    logic [WIDTH-1:0]     quotient, remainder;
    logic [WIDTH-1:0]     fix_hi, fix_lo;

    // Decode the incoming request and form unsigned operand magnitudes.
    always_comb begin
        op_in     = mdu_op_e'(op);
        signed_in = op_is_signed(op_in);
        a_mag     = (signed_in && Read_Data_1[WIDTH-1]) ? -Read_Data_1 : Read_Data_1;
        b_mag     = (signed_in && Read_Data_2[WIDTH-1]) ? -Read_Data_2 : Read_Data_2;
        idle_like = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
        accept    = idle_like && start;
        last_iter = (iter_reg == MDU_CNT_W'(MDU_ITER - 1));
    end

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic; a fast multiply skips straight to the fix cycle.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (FAST_MUL && !op_is_div(op_in)) state_next = ST_FIX;
                    else                                state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN:  if (last_iter) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Latch operation context on an accepted start; count iterations in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iter_reg     <= '0;
            op_reg       <= OP_MULT;
            neg_a_reg    <= 1'b0;
            neg_b_reg    <= 1'b0;
            dividend_reg <= '0;
            zero_div_reg <= 1'b0;
        end else if (accept) begin
            iter_reg     <= '0;
            op_reg       <= op_in;
            neg_a_reg    <= signed_in && Read_Data_1[WIDTH-1];
            neg_b_reg    <= signed_in && Read_Data_2[WIDTH-1];
            dividend_reg <= Read_Data_1;
            zero_div_reg <= (Read_Data_2 == '0);
        end else if (state_reg == ST_RUN) begin
            iter_reg <= iter_reg + MDU_CNT_W'(1);
        end
    end

`ifdef MDU_FAST_MUL_EN
    // Hold the magnitudes; the product is formed combinationally in FIX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_reg   <= '0;
            prod_lo_reg <= '0;
        end else if (accept) begin
            mcand_reg   <= a_mag;
            prod_lo_reg <= b_mag;
        end
    end

    // Single-cycle magnitude product.
    always_comb begin
        mag_prod = {{WIDTH{1'b0}}, mcand_reg} * {{WIDTH{1'b0}}, prod_lo_reg};
    end
`else
    logic [WIDTH-1:0] prod_hi_reg;
    logic [WIDTH:0]   mul_sum;

    // Add the multiplicand when the current multiplier bit is set.
    always_comb begin
        mul_sum = {1'b0, prod_hi_reg} + (prod_lo_reg[0] ? {1'b0, mcand_reg} : '0);
    end

    // Shift-add multiplier: the multiplier drains out of the low half as the
    // product fills in from the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_reg   <= '0;
            prod_hi_reg <= '0;
            prod_lo_reg <= '0;
        end else if (accept) begin
            mcand_reg   <= a_mag;
            prod_hi_reg <= '0;
            prod_lo_reg <= b_mag;
        end else if (state_reg == ST_RUN && !op_is_div(op_reg)) begin
            prod_hi_reg <= mul_sum[WIDTH:1];
            prod_lo_reg <= {mul_sum[0], prod_lo_reg[WIDTH-1:1]};
        end
    end

    // The accumulated magnitude product.
    always_comb begin
        mag_prod = {prod_hi_reg, prod_lo_reg};
    end
`endif

    mdu_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .step      ((state_reg == ST_RUN) && op_is_div(op_reg)),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Sign-correct the magnitude result; zero divisor yields all-ones/dividend.
    always_comb begin
        signed_prod = (neg_a_reg ^ neg_b_reg) ? -mag_prod : mag_prod;
        if (op_is_div(op_reg)) begin
            if (zero_div_reg) begin
                fix_hi = dividend_reg;
                fix_lo = '1;
            end else begin
                fix_hi = neg_a_reg ? -remainder : remainder;
                fix_lo = (neg_a_reg ^ neg_b_reg) ? -quotient : quotient;
            end
        end else begin
            fix_hi = signed_prod[2*WIDTH-1:WIDTH];
            fix_lo = signed_prod[WIDTH-1:0];
        end
    end

    // Architectural HI/LO: results at FIX exit, MTHI/MTLO only when idle and
    // not starting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_reg       <= '0;
            lo_reg       <= '0;
            div_zero_reg <= 1'b0;
        end else if (state_reg == ST_FIX) begin
            hi_reg       <= fix_hi;
            lo_reg       <= fix_lo;
            div_zero_reg <= op_is_div(op_reg) && zero_div_reg;
        end else if (accept) begin
            div_zero_reg <= 1'b0;
        end else if (idle_like) begin
            if (hi_we) hi_reg <= Write_Data;
            if (lo_we) lo_reg <= Write_Data;
        end
    end

    assign busy     = (state_reg == ST_RUN) || (state_reg == ST_FIX);
    assign done     = (state_reg == ST_DONE);
    assign Hi       = hi_reg;
    assign Lo       = lo_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations checked against an arithmetic reference model.
module tb_mult_div_unit;

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rd1 = '0, rd2 = '0, wd = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done, div_zero;
    logic [31:0] Hi, Lo;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .Read_Data_1 (rd1),
        .Read_Data_2 (rd2),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .Write_Data  (wd),
        .busy        (busy),
        .done        (done),
        .Hi          (Hi),
        .Lo          (Lo),
        .div_zero    (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {hi, lo} from plain arithmetic on the operation definitions.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: res = sa * sb;
            2'b01: res = {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Issue one operation and check latency, result and flags.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input bit with_write, input bit chk_pulse);
        logic [63:0] e;
        int cyc;
        int lat;
        e   = ref_model(o, a, b);
        lat = (FAST && !o[1]) ? 1 : 33;
        @(negedge clk);
        start = 1'b1; op = o; rd1 = a; rd2 = b;
        if (with_write) begin
            hi_we = 1'b1; lo_we = 1'b1; wd = 32'h5A5A_A5A5;
        end
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        rd1 = $urandom; rd2 = $urandom;
        check("busy_after_start", {63'h0, busy}, 64'h1);
        check("div_zero_cleared", {63'h0, div_zero}, 64'h0);
        if (with_write) begin
            check("start_wins_hi", {32'h0, Hi}, {32'h0, exp_hi});
            check("start_wins_lo", {32'h0, Lo}, {32'h0, exp_lo});
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (disturb && cyc == 9) begin
                start = 1'b1; op = o ^ 2'b01; rd1 = ~a; rd2 = b + 32'd1;
                hi_we = 1'b1; lo_we = 1'b1; wd = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            cyc++;
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            if (disturb && cyc == 10) begin
                check("busy_hold_busy", {63'h0, busy}, 64'h1);
                check("busy_hold_hi", {32'h0, Hi}, {32'h0, exp_hi});
                check("busy_hold_lo", {32'h0, Lo}, {32'h0, exp_lo});
            end
        end
        check("latency", 64'(cyc), 64'(lat));
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        check("result_hi", {32'h0, Hi}, {32'h0, exp_hi});
        check("result_lo", {32'h0, Lo}, {32'h0, exp_lo});
        check("div_zero", {63'h0, div_zero}, {63'h0, (o[1] && b == 32'h0)});
        check("busy_at_done", {63'h0, busy}, 64'h0);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d cycles=%0d",
                 o, a, b, Hi, Lo, div_zero, cyc);
        if (chk_pulse) begin
            @(posedge clk); #1;
            check("done_one_cycle", {63'h0, done}, 64'h0);
            check("idle_not_busy", {63'h0, busy}, 64'h0);
            check("hold_hi", {32'h0, Hi}, {32'h0, exp_hi});
        end
    endtask

    // MTHI/MTLO while idle.
    task automatic move_to(input bit to_hi, input bit to_lo, input logic [31:0] d);
        @(negedge clk);
        hi_we = to_hi; lo_we = to_lo; wd = d;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        if (to_hi) exp_hi = d;
        if (to_lo) exp_lo = d;
        check("mt_hi", {32'h0, Hi}, {32'h0, exp_hi});
        check("mt_lo", {32'h0, Lo}, {32'h0, exp_lo});
        $display("mthi=%0d mtlo=%0d data=%h -> hi=%h lo=%h", to_hi, to_lo, d, Hi, Lo);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int sel;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", {32'h0, Hi}, 64'h0);
        check("rst_lo", {32'h0, Lo}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_div_zero", {63'h0, div_zero}, 64'h0);
        reset = 1'b0;

        // Directed cases; the first start lands on the first edge after reset
        run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0, 1);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 1);
        run_op(2'b11, 32'd100, 32'd0, 0, 0, 1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1);
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 0, 0, 1);

        // MTHI/MTLO, then start with simultaneous writes
        move_to(1, 0, 32'h1234_5678);
        move_to(0, 1, 32'h8765_4321);
        run_op(2'b11, 32'd1000, 32'd7, 0, 1, 1);

        // Start and writes during a divide are ignored
        run_op(2'b10, 32'h8000_0001, 32'hFFFF_FFFD, 1, 0, 1);

        // Back-to-back: next start is taken in the DONE cycle
        run_op(2'b00, 32'd12345, 32'hFFFF_0000, 0, 0, 0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'd3, 0, 0, 1);

        // Reset in the middle of a MULT
        @(negedge clk);
        start = 1'b1; op = 2'b00; rd1 = 32'h0001_0001; rd2 = 32'h0003_0003;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        check("midrst_hi", {32'h0, Hi}, 64'h0);
        check("midrst_lo", {32'h0, Lo}, 64'h0);
        check("midrst_busy", {63'h0, busy}, 64'h0);
        check("midrst_done", {63'h0, done}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        $display("reset asserted during MULT -> hi=%h lo=%h busy=%0d", Hi, Lo, busy);
        run_op(2'b00, 32'd6, 32'd7, 0, 0, 1);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'h0;
            if (sel == 1) rb = 32'($urandom_range(1, 15));
            if (sel == 2) ra = 32'h8000_0000;
            if (sel == 3) rb = 32'hFFFF_FFFF;
            run_op(ro, ra, rb, 0, 0, ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
